// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the game top and the sync generator,
// plus the sync/active triple that travels down the video-alignment pipeline.
package vga_timing_pkg;

    localparam int c_COUNT_W       = 10;
    localparam int c_COUNT_MAX     = (1 << c_COUNT_W) - 1;

    localparam int c_TOTAL_COLS    = 800;
    localparam int c_TOTAL_ROWS    = 525;
    localparam int c_ACTIVE_COLS   = 640;
    localparam int c_ACTIVE_ROWS   = 480;
    localparam int c_H_FRONT_PORCH = 16;
    localparam int c_H_SYNC_WIDTH  = 96;
    localparam int c_V_FRONT_PORCH = 10;
    localparam int c_V_SYNC_WIDTH  = 2;
    localparam int c_MAX_LATENCY   = 7;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic active;
    } sync_t;

    // Blanked, syncs inactive: what the pins show while the pipeline refills.
    localparam sync_t c_SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, active: 1'b0};

    // Half-open window test [lo, hi) on an unsigned count.
    function automatic logic in_window(
        input logic [c_COUNT_W-1:0] value,
        input logic [c_COUNT_W-1:0] lo,
        input logic [c_COUNT_W-1:0] hi
    );
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with asynchronous reset to a chosen word.
// Depth 0 degenerates to a plain wire.
module sync_delay_line #(
    parameter int                 DEPTH       = 1,
    parameter int                 WIDTH       = 3,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [WIDTH-1:0] i_Data,
    output logic [WIDTH-1:0] o_Data
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_Data = i_Data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RESET_VALUE;
                    end
                end else begin
                    r_stage[0] <= i_Data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_Data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing source: free-running column/row counters, sync/active decode,
// a latency-matching delay line and a blanking output register for the DAC.
module vga_sync_gen #(
    parameter int c_TOTAL_COLS    = vga_timing_pkg::c_TOTAL_COLS,
    parameter int c_TOTAL_ROWS    = vga_timing_pkg::c_TOTAL_ROWS,
    parameter int c_ACTIVE_COLS   = vga_timing_pkg::c_ACTIVE_COLS,
    parameter int c_ACTIVE_ROWS   = vga_timing_pkg::c_ACTIVE_ROWS,
    parameter int c_H_FRONT_PORCH = vga_timing_pkg::c_H_FRONT_PORCH,
    parameter int c_H_SYNC_WIDTH  = vga_timing_pkg::c_H_SYNC_WIDTH,
    parameter int c_V_FRONT_PORCH = vga_timing_pkg::c_V_FRONT_PORCH,
    parameter int c_V_SYNC_WIDTH  = vga_timing_pkg::c_V_SYNC_WIDTH,
    parameter int c_VIDEO_LATENCY = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Red_Video,
    input  logic [3:0] i_Grn_Video,
    input  logic [3:0] i_Blu_Video,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Active,
    output logic       o_Frame_Start,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [3:0] o_Red_Video,
    output logic [3:0] o_Grn_Video,
    output logic [3:0] o_Blu_Video
);

    import vga_timing_pkg::*;

    localparam int c_H_SYNC_END = c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH;
    localparam int c_V_SYNC_END = c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH;

    generate
        if (c_H_SYNC_END > c_TOTAL_COLS || c_V_SYNC_END > c_TOTAL_ROWS ||
            c_TOTAL_COLS > c_COUNT_MAX  || c_TOTAL_ROWS > c_COUNT_MAX  ||
            c_TOTAL_COLS < 1            || c_TOTAL_ROWS < 1            ||
            c_VIDEO_LATENCY < 0         || c_VIDEO_LATENCY > c_MAX_LATENCY) begin : g_bad_params
            $error("vga_sync_gen: timing parameters out of range");
        end
    endgenerate

    localparam logic [9:0] c_COL_LAST  = 10'(c_TOTAL_COLS - 1);
    localparam logic [9:0] c_ROW_LAST  = 10'(c_TOTAL_ROWS - 1);
    localparam logic [9:0] c_COL_VIS   = 10'(c_ACTIVE_COLS);
    localparam logic [9:0] c_ROW_VIS   = 10'(c_ACTIVE_ROWS);
    localparam logic [9:0] c_HS_START  = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
    localparam logic [9:0] c_HS_STOP   = 10'(c_H_SYNC_END);
    localparam logic [9:0] c_VS_START  = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
    localparam logic [9:0] c_VS_STOP   = 10'(c_V_SYNC_END);

    logic [9:0] r_col;
    logic [9:0] r_row;
    sync_t      w_sync;
    sync_t      w_sync_dly;
    logic       r_hsync;
    logic       r_vsync;
    logic [3:0] w_video_in [3];

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_col == c_COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 10'd1;
        end else begin
            r_col <= r_col + 10'd1;
        end
    end

    // The row only moves on a column wrap, so VSync can only toggle at column 0.
    always_comb begin
        w_sync        = c_SYNC_IDLE;
        w_sync.active = (r_col < c_COL_VIS) && (r_row < c_ROW_VIS);
        w_sync.hs_n   = ~in_window(r_col, c_HS_START, c_HS_STOP);
        w_sync.vs_n   = ~in_window(r_row, c_VS_START, c_VS_STOP);
    end

    sync_delay_line #(
        .DEPTH       (c_VIDEO_LATENCY),
        .WIDTH       ($bits(sync_t)),
        .RESET_VALUE (c_SYNC_IDLE)
    ) u_sync_delay (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Data (w_sync),
        .o_Data (w_sync_dly)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_hsync <= w_sync_dly.hs_n;
            r_vsync <= w_sync_dly.vs_n;
        end
    end

    assign w_video_in[0] = i_Red_Video;
    assign w_video_in[1] = i_Grn_Video;
    assign w_video_in[2] = i_Blu_Video;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [3:0] r_chan;

            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    r_chan <= '0;
                end else begin
                    r_chan <= w_sync_dly.active ? w_video_in[gi] : 4'h0;
                end
            end
        end
    endgenerate

    assign o_Col_Count   = r_col;
    assign o_Row_Count   = r_row;
    assign o_Active      = w_sync.active;
    assign o_Frame_Start = (r_col == '0) && (r_row == '0);
    assign o_HSync       = r_hsync;
    assign o_VSync       = r_vsync;
    assign o_Red_Video   = g_chan[0].r_chan;
    assign o_Grn_Video   = g_chan[1].r_chan;
    assign o_Blu_Video   = g_chan[2].r_chan;

endmodule
